airlock_pressure_seq: RTL

Parametrised successor to the airlock fill/pressurize controller. Runs either a pressurize (fill) cycle or an evacuate (drain) cycle on one chamber. Enforces door interlocks, a minimum pump time and a timeout, and reports done, reject and fault status. It sits between the airlock top-level FSM (begin requests) and the pump/sensor interface.

---
 rtl/airlock_pressure_seq_if.sv | 30 +++
 rtl/airlock_pressure_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/airlock_pressure_seq_if.sv
// Bus between the airlock top-level FSM / pump-sensor block and airlock_pressure_seq.
// The controller attaches through the slave modport; the requester side uses master.
interface airlock_pressure_seq_if;
  logic       begin_FandP;
  logic       begin_Evac;
  logic       InnerClosed;
  logic       OuterClosed;
  logic       Pressurized;
  logic       Evacuated;
  logic       clear_fault;
  logic       pump_fill;
  logic       pump_drain;
  logic       busy;
  logic       done;
  logic       reject;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output begin_FandP, begin_Evac, InnerClosed, OuterClosed,
           Pressurized, Evacuated, clear_fault,
    input  pump_fill, pump_drain, busy, done, reject, fault, fault_code
  );

  modport slave (
    input  begin_FandP, begin_Evac, InnerClosed, OuterClosed,
           Pressurized, Evacuated, clear_fault,
    output pump_fill, pump_drain, busy, done, reject, fault, fault_code
  );
endinterface

// File: rtl/airlock_pressure_seq.sv
// Airlock pressurize/evacuate sequencer with door interlock, minimum pump time and timeout.
// Optional feature macro: PRESSURE_SETTLE_EN (sensor must hold for SETTLE_CYCLES before done).
module airlock_pressure_seq #(
  parameter int FILL_CYCLES    = 4,
  parameter int DRAIN_CYCLES   = 6,
  parameter int TIMEOUT_CYCLES = 10,
`ifdef PRESSURE_SETTLE_EN
  parameter int SETTLE_CYCLES  = 3,
`endif
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  airlock_pressure_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_DONE,
`ifdef PRESSURE_SETTLE_EN
    S_SETTLE,
`endif
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_DOOR    = 2'd1,
    FC_TIMEOUT = 2'd2
  } fault_code_e;

  localparam logic [CW-1:0] FILL_MIN  = CW'(FILL_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_MIN = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_CYCLES - 1);

`ifdef PRESSURE_SETTLE_EN
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
  logic [SW-1:0] settle_q, settle_d;
`endif

  state_e      state_q, state_d;
  fault_code_e code_q, code_d;
  logic        fill_mode_q, fill_mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        reject_d;

  logic        pump_fill_q, pump_drain_q, busy_q, done_q, reject_q, fault_q;

  logic          doors_ok;
  logic          sensor;
  logic          min_reached;
  logic [CW-1:0] cnt_inc;

  // The mode bit remembers which cycle is running so SETTLE can resume the right pump state.
  assign doors_ok    = bus.InnerClosed & bus.OuterClosed;
  assign sensor      = fill_mode_q ? bus.Pressurized : bus.Evacuated;
  assign min_reached = cnt_q >= (fill_mode_q ? FILL_MIN : DRAIN_MIN);
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d     = state_q;
    code_d      = code_q;
    fill_mode_d = fill_mode_q;
    cnt_d       = cnt_q;
    reject_d    = 1'b0;
`ifdef PRESSURE_SETTLE_EN
    settle_d    = settle_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.begin_FandP || bus.begin_Evac) begin
          if (doors_ok) begin
            state_d     = bus.begin_FandP ? S_FILL : S_DRAIN;
            fill_mode_d = bus.begin_FandP;
            cnt_d       = '0;
          end else begin
            reject_d    = 1'b1;
          end
        end
      end
      S_FILL, S_DRAIN: begin
        cnt_d = cnt_inc;
        if (!doors_ok) begin
          state_d = S_FAULT;
          code_d  = FC_DOOR;
        end else if (sensor && min_reached) begin
`ifdef PRESSURE_SETTLE_EN
          state_d  = S_SETTLE;
          settle_d = '0;
`else
          state_d  = S_DONE;
`endif
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_FAULT;
          code_d  = FC_TIMEOUT;
        end
      end
`ifdef PRESSURE_SETTLE_EN
      // cnt is frozen here and kept on a sensor drop so the timeout budget carries over.
      S_SETTLE: begin
        if (!doors_ok) begin
          state_d = S_FAULT;
          code_d  = FC_DOOR;
        end else if (!sensor) begin
          state_d = fill_mode_q ? S_FILL : S_DRAIN;
        end else if (settle_q == SETTLE_MAX) begin
          state_d = S_DONE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      S_FAULT: begin
        if (bus.clear_fault) begin
          state_d = S_IDLE;
          code_d  = FC_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a flop aligned with its state.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (Reset) begin
      state_q      <= S_IDLE;
      code_q       <= FC_NONE;
      fill_mode_q  <= 1'b0;
      cnt_q        <= '0;
`ifdef PRESSURE_SETTLE_EN
      settle_q     <= '0;
`endif
      pump_fill_q  <= 1'b0;
      pump_drain_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reject_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      fill_mode_q  <= fill_mode_d;
      cnt_q        <= cnt_d;
`ifdef PRESSURE_SETTLE_EN
      settle_q     <= settle_d;
      pump_fill_q  <= (state_d == S_FILL)  || ((state_d == S_SETTLE) &&  fill_mode_d);
      pump_drain_q <= (state_d == S_DRAIN) || ((state_d == S_SETTLE) && !fill_mode_d);
`else
      pump_fill_q  <= (state_d == S_FILL);
      pump_drain_q <= (state_d == S_DRAIN);
`endif
      busy_q       <= !(state_d inside {S_IDLE, S_FAULT});
      done_q       <= (state_d == S_DONE);
      reject_q     <= reject_d;
      fault_q      <= (state_d == S_FAULT);
    end
  end

  assign bus.pump_fill  = pump_fill_q;
  assign bus.pump_drain = pump_drain_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.reject     = reject_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule
